// File: rtl/mc_main_fsm_pkg.sv
// Shared types and encodings for the multicycle controller.
// Covers the state encoding, instruction fields, ALU commands and the per-state control word.
package mc_main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       adr_src;
      logic       alu_op;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
   } ctrl_t;

   // Moore control word for a state; anything not set stays 0.
   function automatic ctrl_t state_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.next_pc    = 1'b1;
            c.alu_src_a  = 2'b01;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 2'b01;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR: c.alu_src_b = 2'b01;
         S_MEMRD:  c.adr_src   = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_w      = 1'b1;
         end
         S_MEMWR: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         S_EXECR: c.alu_op = 1'b1;
         S_EXECI: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = 1'b1;
         end
         S_ALUWB: c.reg_w = 1'b1;
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Controller <-> datapath bundle: instruction fields in, strobes and selects out.
// The master side is the controller and the slave side is the datapath.
interface mc_main_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IRWrite;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       AdrSrc;
   logic       NoWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] FlagW;
   logic [3:0] StateDbg;

   modport master (
      input  Op, Funct,
      output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, NoWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, FlagW, StateDbg
   );

   modport slave (
      output Op, Funct,
      input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, NoWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, FlagW, StateDbg
   );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: turns ALUOp and the cmd/S fields into ALUControl, FlagW and NoWrite.
// It is purely combinational; outside the execute states it requests an add with no flag updates.
module mc_aludec
   import mc_main_fsm_pkg::*;
(
   input  logic       alu_op_i,
   input  logic [4:0] funct_i,
   output logic [1:0] alu_control_o,
   output logic [1:0] flag_w_o,
   output logic       no_write_o
);

   // NOTE: every output gets a default before the branches so no latch is inferred.
   always_comb begin
      alu_control_o = ALU_ADD;
      flag_w_o      = 2'b00;
      no_write_o    = 1'b0;
      if (alu_op_i) begin
         case (funct_i[4:1])
            CMD_ADD: alu_control_o = ALU_ADD;
            CMD_SUB: alu_control_o = ALU_SUB;
            CMD_AND: alu_control_o = ALU_AND;
            CMD_ORR: alu_control_o = ALU_ORR;
            CMD_CMP: alu_control_o = ALU_SUB;
            default: alu_control_o = ALU_ADD;
         endcase
         // The C and V flags only make sense for arithmetic operations.
         flag_w_o[1] = funct_i[0];
         flag_w_o[0] = funct_i[0] &
                       ((alu_control_o == ALU_ADD) || (alu_control_o == ALU_SUB));
         if (funct_i[4:1] == CMD_CMP) begin
            flag_w_o   = 2'b11;
            no_write_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle controller main FSM: the next-state decoder plus registered Moore control outputs.
// The ALU decoder hangs off the registered ALUOp.
module mc_main_fsm
   import mc_main_fsm_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   mc_main_fsm_if.master  bus
);

   state_e     state_q, state_d;
   ctrl_t      ctrl_q;
   logic       no_write_q;
   logic [1:0] alu_control;
   logic [1:0] flag_w;
   logic       dec_no_write;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               OP_ILL:  state_d = S_FETCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so that they always match state_q.
   // NOTE: reset loads the FETCH control word rather than zero, so reset and FETCH look identical.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         ctrl_q     <= state_ctrl(S_FETCH);
         no_write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
         if (ctrl_q.alu_op) begin
            no_write_q <= dec_no_write;
         end
      end
   end

   mc_aludec u_aludec (
      .alu_op_i      (ctrl_q.alu_op),
      .funct_i       (bus.Funct[4:0]),
      .alu_control_o (alu_control),
      .flag_w_o      (flag_w),
      .no_write_o    (dec_no_write)
   );

   assign bus.IRWrite    = ctrl_q.ir_write;
   assign bus.NextPC     = ctrl_q.next_pc;
   assign bus.RegW       = ctrl_q.reg_w;
   assign bus.MemW       = ctrl_q.mem_w;
   assign bus.Branch     = ctrl_q.branch;
   assign bus.AdrSrc     = ctrl_q.adr_src;
   assign bus.ResultSrc  = ctrl_q.result_src;
   assign bus.ALUSrcA    = ctrl_q.alu_src_a;
   assign bus.ALUSrcB    = ctrl_q.alu_src_b;
   assign bus.ALUControl = alu_control;
   assign bus.FlagW      = flag_w;
   // A compare suppresses the writeback that follows it in ALUWB.
   assign bus.NoWrite    = dec_no_write | ((state_q == S_ALUWB) & no_write_q);
   assign bus.StateDbg   = state_q;

endmodule
